udp_tx_scheduler: RTL and testbench



---
 rtl/udp_tx_scheduler_if.sv | 21 ++
 rtl/udp_tx_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_udp_tx_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_scheduler_if.sv
// UDP transmit handshake between the scheduler (master) and the udp instance (slave).
// The scheduler drives the start/data side; udp returns word requests and frame completion.
interface udp_tx_scheduler_if;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        tx_done;
  logic [2:0]  tx_ch_id;
  logic        tx_timeout;

  modport master (
    output tx_start_en, tx_byte_num, tx_data, tx_ch_id, tx_timeout,
    input  tx_req, tx_done
  );

  modport slave (
    input  tx_start_en, tx_byte_num, tx_data, tx_ch_id, tx_timeout,
    output tx_req, tx_done
  );
endinterface

// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one UDP transmit path between NUM_CH payload sources,
// with per-channel holding registers, inter-frame gap and tx_done timeout recovery.
module udp_tx_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int PAYLOAD_BITS   = 88,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           gmii_tx_clk,
  input  logic                           sys_rst_n,
  input  logic                           enable,
  input  logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0] ch_payload,
  output logic [NUM_CH-1:0]              ch_pending,
  output logic [NUM_CH-1:0]              ch_drop,
  output logic                           busy,
  udp_tx_scheduler_if.master             udp_tx
);

  localparam int PAYLOAD_BYTES = (PAYLOAD_BITS + 7) / 8;
  localparam int WORDS         = (PAYLOAD_BYTES + 3) / 4;
  localparam int ACT_W         = WORDS * 32;
  localparam int IDX_W         = $clog2(WORDS + 1);
  localparam int TMR_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W         = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BUSY, ST_GAP} state_t;

  state_t                  state_r;
  logic [NUM_CH-1:0]       pending_r;
  logic [NUM_CH-1:0]       ch_drop_r;
  logic [PAYLOAD_BITS-1:0] buf_r [NUM_CH];
  logic [ACT_W-1:0]        active_r;
  logic [IDX_W-1:0]        word_idx_r;
  logic [31:0]             tx_data_r;
  logic [2:0]              last_grant_r;
  logic [2:0]              tx_ch_id_r;
  logic                    tx_start_en_r;
  logic                    tx_timeout_r;
  logic                    busy_r;
  logic [TMR_W-1:0]        timer_r;
  logic [GAP_W-1:0]        gap_cnt_r;

  logic                    found_hi_s;
  logic                    found_lo_s;
  logic [2:0]              hi_ch_s;
  logic [2:0]              lo_ch_s;
  logic [2:0]              grant_ch_s;
  logic                    grant_s;
  logic [NUM_CH-1:0]       grant_mask_s;
  logic [PAYLOAD_BITS-1:0] grant_buf_s;
  logic [31:0]             word_s;

  // Round-robin pick: first pending channel above last_grant, else the lowest at/below it.
  always_comb begin
    found_hi_s   = 1'b0;
    found_lo_s   = 1'b0;
    hi_ch_s      = 3'd0;
    lo_ch_s      = 3'd0;
    grant_mask_s = {NUM_CH{1'b0}};
    grant_buf_s  = {PAYLOAD_BITS{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      hi_ch_s    = (!found_hi_s && pending_r[c] && (3'(c) > last_grant_r)) ? 3'(c) : hi_ch_s;
      found_hi_s = found_hi_s || (pending_r[c] && (3'(c) > last_grant_r));
      lo_ch_s    = (!found_lo_s && pending_r[c] && (3'(c) <= last_grant_r)) ? 3'(c) : lo_ch_s;
      found_lo_s = found_lo_s || (pending_r[c] && (3'(c) <= last_grant_r));
    end
    grant_ch_s = found_hi_s ? hi_ch_s : lo_ch_s;
    grant_s    = (state_r == ST_IDLE) && enable && (found_hi_s || found_lo_s);
    for (int c = 0; c < NUM_CH; c++) begin
      grant_mask_s[c] = grant_s && (grant_ch_s == 3'(c));
      grant_buf_s     = (grant_ch_s == 3'(c)) ? buf_r[c] : grant_buf_s;
    end
  end

  // Active word selected by word_idx, MSB-first; past the last word the feed returns zero.
  always_comb begin
    word_s = 32'h0000_0000;
    for (int w = 0; w < WORDS; w++) begin
      word_s = (word_idx_r == IDX_W'(w)) ? active_r[(WORDS-1-w)*32 +: 32] : word_s;
    end
  end

  // Frame sequencing: grant, start pulse, wait for tx_done or timeout, then inter-frame gap.
  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= ST_IDLE;
      tx_start_en_r <= 1'b0;
      tx_timeout_r  <= 1'b0;
      busy_r        <= 1'b0;
      timer_r       <= {TMR_W{1'b0}};
      gap_cnt_r     <= {GAP_W{1'b0}};
      last_grant_r  <= 3'(NUM_CH - 1);
      tx_ch_id_r    <= 3'd0;
      active_r      <= {ACT_W{1'b0}};
    end else begin
      tx_start_en_r <= 1'b0;
      tx_timeout_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            state_r       <= ST_START;
            tx_start_en_r <= 1'b1;
            busy_r        <= 1'b1;
            timer_r       <= {TMR_W{1'b0}};
            last_grant_r  <= grant_ch_s;
            tx_ch_id_r    <= grant_ch_s;
            active_r      <= ACT_W'(grant_buf_s) << (ACT_W - PAYLOAD_BITS);
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_START: begin
          // The start cycle is the first cycle of the timeout window.
          timer_r <= TMR_W'(1);
          state_r <= ST_BUSY;
        end
        ST_BUSY: begin
          if (udp_tx.tx_done) begin
            state_r   <= ST_GAP;
            gap_cnt_r <= {GAP_W{1'b0}};
          end else if (timer_r == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state_r      <= ST_GAP;
            gap_cnt_r    <= {GAP_W{1'b0}};
            tx_timeout_r <= 1'b1;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Holding registers: capture when empty or being granted this cycle, otherwise drop.
  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending_r <= {NUM_CH{1'b0}};
      ch_drop_r <= {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        buf_r[c] <= {PAYLOAD_BITS{1'b0}};
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_drop_r[c] <= ch_valid[c] && pending_r[c] && !grant_mask_s[c];
        if (ch_valid[c] && (!pending_r[c] || grant_mask_s[c])) begin
          buf_r[c]     <= ch_payload[c*PAYLOAD_BITS +: PAYLOAD_BITS];
          pending_r[c] <= 1'b1;
        end else if (grant_mask_s[c]) begin
          pending_r[c] <= 1'b0;
        end
      end
    end
  end

  // Word feed: each tx_req loads the next word and advances word_idx up to WORDS.
  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      word_idx_r <= {IDX_W{1'b0}};
      tx_data_r  <= 32'h0000_0000;
    end else if (grant_s) begin
      word_idx_r <= {IDX_W{1'b0}};
    end else if (udp_tx.tx_req) begin
      tx_data_r <= word_s;
      if (word_idx_r != IDX_W'(WORDS)) begin
        word_idx_r <= word_idx_r + IDX_W'(1);
      end
    end
  end

  assign ch_pending         = pending_r;
  assign ch_drop            = ch_drop_r;
  assign busy               = busy_r;
  assign udp_tx.tx_start_en = tx_start_en_r;
  assign udp_tx.tx_timeout  = tx_timeout_r;
  assign udp_tx.tx_data     = tx_data_r;
  assign udp_tx.tx_ch_id    = tx_ch_id_r;
  assign udp_tx.tx_byte_num = 16'(PAYLOAD_BYTES);

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Bench for udp_tx_scheduler: directed scenarios plus random traffic, checked every cycle
// against a timestamp-based reference model of the scheduling rules.
module tb_udp_tx_scheduler;
  localparam int NUM_CH = 4;
  localparam int PB     = 88;
  localparam int GAP    = 16;
  localparam int TMO    = 4096;
  localparam int WORDS  = 3;
  localparam int ACTW   = WORDS * 32;

  logic                   gmii_tx_clk = 1'b0;
  logic                   sys_rst_n   = 1'b0;
  logic                   enable      = 1'b0;
  logic [NUM_CH-1:0]      ch_valid    = '0;
  logic [NUM_CH*PB-1:0]   ch_payload  = '0;
  logic [NUM_CH-1:0]      ch_pending;
  logic [NUM_CH-1:0]      ch_drop;
  logic                   busy;

  udp_tx_scheduler_if udp_tx ();

  udp_tx_scheduler #(
    .NUM_CH(NUM_CH), .PAYLOAD_BITS(PB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .gmii_tx_clk(gmii_tx_clk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .ch_valid   (ch_valid),
    .ch_payload (ch_payload),
    .ch_pending (ch_pending),
    .ch_drop    (ch_drop),
    .busy       (busy),
    .udp_tx     (udp_tx)
  );

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  logic [PB-1:0]     mbuf [NUM_CH];
  logic [NUM_CH-1:0] mpend;
  int                mlast;
  bit                in_frame;
  int                mstart;
  int                idle_at;
  logic [ACTW-1:0]   mact;
  int                midx;
  // predicted outputs for the next cycle
  logic              e_start, e_tmo, e_busy;
  logic [NUM_CH-1:0] e_drop, e_pend;
  logic [31:0]       e_data;
  logic [2:0]        e_ch;
  // udp responder and observation logs
  int  resp_delay = 20;
  bit  rnd_req    = 1'b0;
  int  spur_pct   = 0;
  bit  req_prev   = 1'b0;
  int  drop1_cnt  = 0;
  int  start_log[$];
  int  done_log[$];
  int  tmo_log[$];
  int  ch_log[$];
  logic [31:0] word_log[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) mbuf[i] = '0;
    mpend = '0; mlast = NUM_CH - 1; in_frame = 1'b0; idle_at = 0; mstart = 0;
    mact = '0; midx = 0;
    e_start = 1'b0; e_tmo = 1'b0; e_busy = 1'b0; e_drop = '0; e_pend = '0;
    e_data = 32'h0; e_ch = 3'd0;
  endtask

  task automatic clear_logs();
    start_log.delete(); done_log.delete(); tmo_log.delete(); ch_log.delete(); word_log.delete();
    drop1_cnt = 0;
  endtask

  // One clock cycle: check outputs, drive the udp side, advance the model, wait for next negedge.
  task automatic step();
    int g;
    bit found;
    check("tx_start_en", 96'(udp_tx.tx_start_en), 96'(e_start));
    check("tx_timeout",  96'(udp_tx.tx_timeout),  96'(e_tmo));
    check("busy",        96'(busy),               96'(e_busy));
    check("ch_drop",     96'(ch_drop),            96'(e_drop));
    check("ch_pending",  96'(ch_pending),         96'(e_pend));
    check("tx_data",     96'(udp_tx.tx_data),     96'(e_data));
    check("tx_ch_id",    96'(udp_tx.tx_ch_id),    96'(e_ch));
    check("tx_byte_num", 96'(udp_tx.tx_byte_num), 96'(11));
    if (udp_tx.tx_start_en) begin start_log.push_back(cyc); ch_log.push_back(int'(udp_tx.tx_ch_id)); end
    if (udp_tx.tx_timeout) tmo_log.push_back(cyc);
    if (req_prev) word_log.push_back(udp_tx.tx_data);
    if (ch_drop[1]) drop1_cnt++;

    if (!sys_rst_n) begin
      udp_tx.tx_req = 1'b0; udp_tx.tx_done = 1'b0; req_prev = 1'b0;
      model_reset();
    end else begin
      if (rnd_req) udp_tx.tx_req = in_frame && ($urandom_range(1, 0) == 1);
      else udp_tx.tx_req = in_frame && (cyc - mstart >= 2) && (cyc - mstart <= 10) && ((cyc - mstart) % 2 == 0);
      udp_tx.tx_done = (in_frame && resp_delay >= 0 && cyc == mstart + resp_delay) ||
                       (!in_frame && $urandom_range(99, 0) < spur_pct);
      req_prev = udp_tx.tx_req;
      e_start = 1'b0; e_tmo = 1'b0; e_drop = '0;
      // frame completion: done counts only after the start cycle; done beats the timeout
      if (in_frame && cyc >= mstart + 1) begin
        if (udp_tx.tx_done) begin
          in_frame = 1'b0; idle_at = cyc + 1 + GAP; done_log.push_back(cyc);
        end else if (cyc == mstart + TMO - 1) begin
          in_frame = 1'b0; idle_at = cyc + 1 + GAP; e_tmo = 1'b1;
        end
      end
      if (!in_frame && cyc >= idle_at && enable && mpend != '0) begin
        found = 1'b0; g = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
          if (!found && mpend[(mlast + k) % NUM_CH]) begin found = 1'b1; g = (mlast + k) % NUM_CH; end
        end
        mact = ACTW'(mbuf[g]) << (ACTW - PB);
        midx = 0; mpend[g] = 1'b0; mlast = g; e_ch = 3'(g); e_start = 1'b1;
        in_frame = 1'b1; mstart = cyc + 1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          if (mpend[i]) e_drop[i] = 1'b1;
          else begin mbuf[i] = ch_payload[i*PB +: PB]; mpend[i] = 1'b1; end
        end
      end
      if (udp_tx.tx_req) begin
        e_data = (midx < WORDS) ? mact[(WORDS-1-midx)*32 +: 32] : 32'h0;
        if (midx < WORDS) midx++;
      end
      e_pend = mpend;
      e_busy = in_frame || (cyc + 1 < idle_at);
    end
    @(negedge gmii_tx_clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m, input logic [PB-1:0] pl);
    ch_valid = m;
    for (int i = 0; i < NUM_CH; i++) if (m[i]) ch_payload[i*PB +: PB] = pl;
    step();
    ch_valid = '0;
  endtask

  task automatic do_reset(input int n);
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    ch_valid = '0;
    run(n);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    udp_tx.tx_req = 1'b0; udp_tx.tx_done = 1'b0;
    model_reset();
    @(negedge gmii_tx_clk);
    run(3);
    sys_rst_n = 1'b1; enable = 1'b1;
    run(2);

    // 1: single frame, latency and word feed with zero padding and saturation
    clear_logs();
    t0 = cyc;
    pulse(4'b0001, 88'h0102030405060708090A0B);
    run(50);
    check("t1_latency", 96'(start_log[0] - t0), 96'(2));
    check("t1_ch", 96'(ch_log[0]), 96'(0));
    check("t1_w0", 96'(word_log[0]), 96'(32'h01020304));
    check("t1_w1", 96'(word_log[1]), 96'(32'h05060708));
    check("t1_w2", 96'(word_log[2]), 96'(32'h090A0B00));
    check("t1_w3", 96'(word_log[3]), 96'(32'h0));

    // 2: all four channels at once, fixed done delay, gap spacing
    do_reset(2);
    clear_logs();
    resp_delay = 50;
    pulse(4'b1111, {$urandom, $urandom, $urandom_range(16777215, 0)});
    run(320);
    check("t2_frames", 96'(start_log.size()), 96'(4));
    for (int k = 0; k < 4; k++) check("t2_order", 96'(ch_log[k]), 96'(k));
    for (int k = 1; k < 4; k++) check("t2_gap", 96'(start_log[k] - done_log[k-1]), 96'(GAP + 2));

    // 3: second trigger while held and disabled is dropped, held data is sent
    clear_logs();
    resp_delay = 20;
    enable = 1'b0;
    pulse(4'b0010, {11{8'hAA}});
    run(3);
    pulse(4'b0010, {11{8'hBB}});
    run(3);
    check("t3_drop_cnt", 96'(drop1_cnt), 96'(1));
    enable = 1'b1;
    run(60);
    check("t3_word", 96'(word_log[0]), 96'(32'hAAAAAAAA));
    check("t3_pending", 96'(ch_pending), 96'(0));

    // 4: capture coinciding with grant keeps the old frame and re-arms the channel
    clear_logs();
    pulse(4'b0100, {11{8'hDD}});
    pulse(4'b0100, {11{8'hCC}});
    check("t4_pending", 96'(ch_pending[2]), 96'(1));
    run(90);
    check("t4_frames", 96'(ch_log.size()), 96'(2));
    check("t4_old", 96'(word_log[0]), 96'(32'hDDDDDDDD));
    check("t4_new", 96'(word_log[5]), 96'(32'hCCCCCCCC));

    // 5: missing tx_done triggers timeout, then the next pending channel runs
    clear_logs();
    resp_delay = -1;
    pulse(4'b1001, {$urandom, $urandom, $urandom_range(16777215, 0)});
    run(4105);
    resp_delay = 20;
    run(60);
    check("t5_tmo_delay", 96'(tmo_log[0] - start_log[0]), 96'(TMO));
    check("t5_next", 96'(start_log[1] - tmo_log[0]), 96'(GAP + 1));
    check("t5_ch", 96'(ch_log[1]), 96'(0));

    // 6: reset mid-frame clears pending state and nothing restarts afterwards
    do_reset(2);
    resp_delay = -1;
    pulse(4'b0111, {$urandom, $urandom, $urandom_range(16777215, 0)});
    run(10);
    check("t6_pending", 96'(ch_pending), 96'(4'b0110));
    do_reset(3);
    clear_logs();
    run(40);
    check("t6_nostart", 96'(start_log.size()), 96'(0));

    // random traffic: triggers, enable toggling, random requests, spurious tx_done
    do_reset(2);
    rnd_req = 1'b1; spur_pct = 10;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_CH; i++) ch_valid[i] = ($urandom_range(99, 0) < 8);
      for (int b = 0; b < NUM_CH * PB; b += 32) ch_payload[b +: 32] = $urandom;
      if (n % 50 == 0) enable = ($urandom_range(9, 0) != 0);
      if (!in_frame) resp_delay = $urandom_range(60, 1);
      step();
    end
    ch_valid = '0;
    run(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
